// File: rtl/register_scoreboard.sv
// Purpose: per-register pending-write counters that stall decode on RAW hazards and on counter saturation.
// Latency: stall/issue are combinational from the decode inputs; counter and busy changes appear one cycle after the edge.
// Backpressure: stall holds decode while a source is pending or the destination counter is full; writeback is never held.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   id_valid/ra/rb    decode holds an instruction; its source indices
//   id_use_a/use_b    the instruction actually reads ra / rb
//   id_we/id_rd       the instruction writes rd
//   wb_valid/wb_rd    writeback retires a write to wb_rd this cycle
//   flush             pipeline squash; drops every pending count
//   stall, issue      hold decode / instruction advances
//   busy              one bit per register with a pending write
//   err               sticky: writeback arrived for a register with no pending write
module register_scoreboard #(
  parameter  int NREG  = 32,
  parameter  int CNT_W = 2,
  localparam int IDX_W = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [IDX_W-1:0] id_ra,
  input  logic [IDX_W-1:0] id_rb,
  input  logic             id_use_a,
  input  logic             id_use_b,
  input  logic             id_we,
  input  logic [IDX_W-1:0] id_rd,
  input  logic             wb_valid,
  input  logic [IDX_W-1:0] wb_rd,
  input  logic             flush,
  output logic             stall,
  output logic             issue,
  output logic [NREG-1:0]  busy,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt [NREG];
  logic [NREG-1:0]  inc_vec;
  logic [NREG-1:0]  dec_vec;
  logic             hazard_a;
  logic             hazard_b;
  logic             hazard_d;
  logic             underflow;

  // Register 0 is hardwired zero, so index 0 never contributes a hazard.
  always_comb begin
    hazard_a = id_use_a && (id_ra != '0) && (cnt[id_ra] != '0);
    hazard_b = id_use_b && (id_rb != '0) && (cnt[id_rb] != '0);
    hazard_d = id_we    && (id_rd != '0) && (cnt[id_rd] == CNT_MAX);
    stall    = id_valid && (hazard_a || hazard_b || hazard_d);
    issue    = id_valid && !stall;
  end

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (issue && id_we && (id_rd != '0))
      inc_vec[id_rd] = 1'b1;
    if (wb_valid && (wb_rd != '0))
      dec_vec[wb_rd] = 1'b1;
    // A retiring write that meets a same-cycle issue nets to zero and is legal
    // even when the count is zero.
    underflow = wb_valid && (wb_rd != '0) && (cnt[wb_rd] == '0) && !inc_vec[wb_rd];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++)
        cnt[r] <= '0;
      err <= 1'b0;
    end else if (flush) begin
      // Squash wins over same-cycle issue and writeback; err is untouched.
      for (int r = 0; r < NREG; r++)
        cnt[r] <= '0;
    end else begin
      cnt[0] <= '0;
      for (int r = 1; r < NREG; r++) begin
        if (inc_vec[r] && !dec_vec[r])
          cnt[r] <= cnt[r] + 1'b1;
        else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != '0))
          cnt[r] <= cnt[r] - 1'b1;
      end
      if (underflow)
        err <= 1'b1;
    end
  end

  always_comb begin
    busy = '0;
    for (int r = 1; r < NREG; r++)
      busy[r] = (cnt[r] != '0);
  end

endmodule

// File: doc/register_scoreboard.md
Name: register_scoreboard

Overview:
- Tracks outstanding writes to the 32-entry register file and stalls the decode stage while a needed source register still has a pending write.
- Sits beside register_file in the pipelined PA-RISC core.
- Decode presents source RA/RB and destination RD before issue; writeback retires destinations as they land.
- Per-register pending counters allow several in-flight writes to the same register (WAW), with saturation back-pressure.

Parameters:
- NREG, 32, number of architectural registers; must match register_file.
- CNT_W, 2, width of each pending counter; max outstanding writes per register = 2^CNT_W - 1 (3).

Ports:
- CLK  input  1  rising-edge clock shared with register_file.
- RST_N  input  1  asynchronous active-low reset.
- ID_VALID  input  1  decode stage holds a valid instruction.
- ID_RA  input  5  source A index.
- ID_RB  input  5  source B index.
- ID_USE_A  input  1  instruction reads RA.
- ID_USE_B  input  1  instruction reads RB.
- ID_WE  input  1  instruction writes RD.
- ID_RD  input  5  destination index.
- WB_VALID  input  1  writeback retires a register write this cycle (the same cycle register_file EN is high).
- WB_RD  input  5  register being written back.
- FLUSH  input  1  pipeline squash; upstream guarantees no squashed write reaches writeback.
- STALL  output  1  combinational; hold decode this cycle.
- ISSUE  output  1  combinational; ID_VALID & ~STALL (instruction advances).
- BUSY  output  32  bit i = counter[i] != 0.
- ERR  output  1  sticky underflow flag.

Behaviour:
- Reset (RST_N low, asynchronous): all counters = 0, BUSY = 0, ERR = 0. STALL and ISSUE follow the combinational equations, so both are 0 when ID_VALID = 0.
- Register 0 is hardwired zero:
  - never counted; BUSY[0] always 0;
  - never causes STALL;
  - issue or writeback to index 0 is ignored and never sets ERR.
- STALL = ID_VALID & any of:
  - ID_USE_A & ID_RA != 0 & cnt[ID_RA] != 0;
  - ID_USE_B & ID_RB != 0 & cnt[ID_RB] != 0;
  - ID_WE & ID_RD != 0 & cnt[ID_RD] == 2^CNT_W - 1 (saturation).
- Counter update, per register r, at the rising CLK edge:
  - inc = ISSUE & ID_WE & ID_RD == r & r != 0.
  - dec = WB_VALID & WB_RD == r & r != 0.
  - inc & dec: count unchanged.
  - inc only: count + 1.
  - dec only with count > 0: count - 1.
  - dec only with count == 0: count stays 0 and ERR sets to 1.
- Same-cycle writeback does not bypass the stall check. If WB retires RA in the same cycle decode checks it, STALL is still 1 that cycle and the instruction issues on the next cycle. The register_file write lands on that edge, so the value read next cycle is correct.
- A source equal to its own destination (e.g. RA == RD) checks the pre-update count; its own issue never stalls itself.
- FLUSH (synchronous, highest priority): all counters = 0 at the edge, overriding same-cycle inc and dec. ERR is not changed.
- ERR clears only on reset.
- Latency: STALL reacts in the same cycle to ID inputs. Counter and BUSY changes are visible one cycle after the edge.
- RST_N asserted mid-operation clears state immediately, without waiting for CLK.

Test Plan:
- Reset with RST_N = 0 while counters are nonzero -> BUSY = 0 and ERR = 0 immediately, without a clock edge.
- Issue ID_WE = 1, ID_RD = 5, then next cycle ID_RA = 5 with ID_USE_A = 1 -> BUSY[5] = 1 and STALL = 1; after WB_VALID, WB_RD = 5 -> the following cycle STALL = 0 and ISSUE = 1.
- Three issues to RD = 7 with no writeback -> cnt = 3; a fourth issue to RD = 7 gives STALL = 1; one writeback to 7 -> the fourth issues next cycle.
- Same-cycle issue RD = 9 and WB_RD = 9 with cnt[9] = 1 -> cnt stays 1 and BUSY[9] stays 1.
- Issue RD = 0 and source RA = 0 -> BUSY = 0 and STALL = 0; WB_RD = 0 -> ERR stays 0.
- Writeback WB_RD = 12 with cnt[12] = 0 -> ERR = 1 and stays 1. With cnt[3] = 2, FLUSH plus a same-cycle issue to 3 -> BUSY = 0 next cycle and ERR still 1.
